// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface: accepts load/store requests, drives
// the memory strobes for a fixed latency per word and returns one response per beat.
module mem_access_unit #(
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 8,
    parameter int ADDR_MAX  = 65535
) (
    input  logic        clk,
    input  logic        in_rst_n,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_req_write,
    input  logic [31:0] in_req_addr,
    input  logic [31:0] in_req_data,
    input  logic [3:0]  in_req_len,
    output logic        out_rsp_valid,
    input  logic        in_rsp_ready,
    output logic [31:0] out_rsp_data,
    output logic        out_rsp_last,
    output logic        out_rsp_err,
    output logic        out_ctrl_read,
    output logic        out_ctrl_write,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    input  logic [31:0] in_mem_data
);

    localparam int LEN_W  = $clog2(MAX_BURST + 1);
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [WAIT_W-1:0] wait_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_last_q;
    logic              rsp_err_q;
    logic              ctrl_read_q;
    logic              ctrl_write_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_data_q;

    logic [LEN_W-1:0]  req_len_d;
    logic [LEN_W-1:0]  next_beat_d;
    logic [32:0]       end_addr_d;
    logic              range_err_d;

    // Stores are always one word; loads clamp to 1..MAX_BURST.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_len_d = LEN_W'(1);
        if (!in_req_write) begin
            if (in_req_len == 4'd0) begin
                req_len_d = LEN_W'(1);
            end else if (int'(in_req_len) > MAX_BURST) begin
                req_len_d = LEN_W'(MAX_BURST);
            end else begin
                req_len_d = LEN_W'(in_req_len);
            end
        end
    end

    // The extra top bit keeps the end-of-burst address from wrapping past 2^32.
    assign end_addr_d  = {1'b0, addr_q} + 33'(len_q) - 33'd1;
    assign range_err_d = end_addr_d > 33'(ADDR_MAX);
    assign next_beat_d = beat_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!in_rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            wait_q       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            ctrl_read_q  <= 1'b0;
            ctrl_write_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_req_valid && req_ready_q) begin
                        write_q     <= in_req_write;
                        addr_q      <= in_req_addr;
                        data_q      <= in_req_data;
                        len_q       <= req_len_d;
                        req_ready_q <= 1'b0;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (range_err_d) begin
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_last_q  <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        beat_q       <= '0;
                        wait_q       <= WAIT_W'(MEM_LAT - 1);
                        ctrl_read_q  <= !write_q;
                        ctrl_write_q <= write_q;
                        mem_addr_q   <= addr_q;
                        mem_data_q   <= write_q ? data_q : 32'd0;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_q == '0) begin
                        rsp_data_q   <= write_q ? 32'd0 : in_mem_data;
                        rsp_last_q   <= (beat_q == len_q - LEN_W'(1));
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        ctrl_read_q  <= 1'b0;
                        ctrl_write_q <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_data_q   <= '0;
                        state_q      <= RESP;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                RESP: begin
                    if (in_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            rsp_data_q  <= '0;
                            rsp_last_q  <= 1'b0;
                            rsp_err_q   <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            beat_q      <= next_beat_d;
                            wait_q      <= WAIT_W'(MEM_LAT - 1);
                            ctrl_read_q <= 1'b1;
                            mem_addr_q  <= addr_q + 32'(next_beat_d);
                            mem_data_q  <= '0;
                            state_q     <= ACCESS;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_req_ready  = req_ready_q;
    assign out_rsp_valid  = rsp_valid_q;
    assign out_rsp_data   = rsp_data_q;
    assign out_rsp_last   = rsp_last_q;
    assign out_rsp_err    = rsp_err_q;
    assign out_ctrl_read  = ctrl_read_q;
    assign out_ctrl_write = ctrl_write_q;
    assign out_addr       = mem_addr_q;
    assign out_data       = mem_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests, with expected strobes and responses
// queued at issue time and compared by independent negedge monitors.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        in_rst_n;
    logic        in_req_valid;
    logic        out_req_ready;
    logic        in_req_write;
    logic [31:0] in_req_addr;
    logic [31:0] in_req_data;
    logic [3:0]  in_req_len;
    logic        out_rsp_valid;
    logic        in_rsp_ready;
    logic [31:0] out_rsp_data;
    logic        out_rsp_last;
    logic        out_rsp_err;
    logic        out_ctrl_read;
    logic        out_ctrl_write;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [31:0] in_mem_data;

    mem_access_unit dut (
        .clk           (clk),
        .in_rst_n      (in_rst_n),
        .in_req_valid  (in_req_valid),
        .out_req_ready (out_req_ready),
        .in_req_write  (in_req_write),
        .in_req_addr   (in_req_addr),
        .in_req_data   (in_req_data),
        .in_req_len    (in_req_len),
        .out_rsp_valid (out_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .out_rsp_last  (out_rsp_last),
        .out_rsp_err   (out_rsp_err),
        .out_ctrl_read (out_ctrl_read),
        .out_ctrl_write(out_ctrl_write),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .in_mem_data   (in_mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: one special word, otherwise a pattern tagged with the address.
    assign in_mem_data = (out_addr == 32'h40) ? 32'hDEADBEEF : {16'hC0DE, out_addr[15:0]};

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } strb_t;

    rsp_t  rsp_q[$];
    strb_t strb_q[$];
    rsp_t  rsp_head;
    strb_t strb_head;
    int    n_total = 0;
    int    n_pass  = 0;
    logic  mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic exp_rsp(input logic [31:0] d, input logic l, input logic e);
        rsp_q.push_back('{data: d, last: l, err: e});
    endtask

    task automatic exp_strb(input logic w, input logic [31:0] a, input logic [31:0] d);
        strb_q.push_back('{wr: w, addr: a, data: d});
    endtask

    // Response monitor: stalled beats are compared against the queue head without popping.
    always @(negedge clk) begin
        if (mon_en && out_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp_valid", 32'(out_rsp_valid), 32'd0);
            end else begin
                rsp_head = rsp_q[0];
                check("rsp_data", out_rsp_data, rsp_head.data);
                check("rsp_last", 32'(out_rsp_last), 32'(rsp_head.last));
                check("rsp_err", 32'(out_rsp_err), 32'(rsp_head.err));
                if (in_rsp_ready) void'(rsp_q.pop_front());
            end
        end
    end

    // Strobe monitor: with MEM_LAT=1 every access is exactly one strobe cycle.
    always @(negedge clk) begin
        if (mon_en && (out_ctrl_read || out_ctrl_write)) begin
            if (strb_q.size() == 0) begin
                check("unexpected_strobe", 32'(out_ctrl_read | out_ctrl_write), 32'd0);
            end else begin
                strb_head = strb_q.pop_front();
                check("strobe_write", 32'(out_ctrl_write), 32'(strb_head.wr));
                check("strobe_read", 32'(out_ctrl_read), 32'(!strb_head.wr));
                check("strobe_addr", out_addr, strb_head.addr);
                check("strobe_data", out_data, strb_head.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] len);
        int n = 0;
        in_req_valid = 1'b1;
        in_req_write = wr;
        in_req_addr  = addr;
        in_req_data  = data;
        in_req_len   = len;
        while (!out_req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!out_req_ready) check("req_ready_timeout", 32'(out_req_ready), 32'd1);
        tick();
        in_req_valid = 1'b0;
        check("req_ready_low_after_accept", 32'(out_req_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || strb_q.size() != 0 || !out_req_ready) && n < 200) begin
            tick();
            n++;
        end
        check("idle_rsp_left", 32'(rsp_q.size()), 32'd0);
        check("idle_strb_left", 32'(strb_q.size()), 32'd0);
        check("idle_req_ready", 32'(out_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        in_rst_n     = 1'b0;
        in_req_valid = 1'b0;
        in_req_write = 1'b0;
        in_req_addr  = '0;
        in_req_data  = '0;
        in_req_len   = '0;
        in_rsp_ready = 1'b1;

        // Reset for three edges, then release.
        repeat (3) tick();
        in_rst_n = 1'b1;
        mon_en   = 1'b1;
        check("rst_req_ready", 32'(out_req_ready), 32'd1);
        check("rst_ctrl_read", 32'(out_ctrl_read), 32'd0);
        check("rst_ctrl_write", 32'(out_ctrl_write), 32'd0);
        check("rst_rsp_valid", 32'(out_rsp_valid), 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        tick();

        // Single load: one read cycle, response two cycles after accept.
        exp_strb(1'b0, 32'h40, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b1, 1'b0);
        send(1'b0, 32'h40, 32'h0, 4'd1);
        check("lat_c0_rsp_valid", 32'(out_rsp_valid), 32'd0);
        tick();
        check("lat_c1_ctrl_read", 32'(out_ctrl_read), 32'd1);
        check("lat_c1_addr", out_addr, 32'h40);
        check("lat_c1_rsp_valid", 32'(out_rsp_valid), 32'd0);
        tick();
        check("lat_c2_rsp_valid", 32'(out_rsp_valid), 32'd1);
        check("lat_c2_ctrl_read", 32'(out_ctrl_read), 32'd0);
        wait_idle();

        // Store ignores len: one write cycle, one response.
        exp_strb(1'b1, 32'h80, 32'h1234);
        exp_rsp(32'h0, 1'b1, 1'b0);
        send(1'b1, 32'h80, 32'h1234, 4'd5);
        wait_idle();

        // Four-beat load with a three-cycle stall on the second beat.
        in_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_strb(1'b0, 32'h100 + 32'(i), 32'h0);
            exp_rsp(32'hC0DE0100 + 32'(i), (i == 3), 1'b0);
        end
        send(1'b0, 32'h100, 32'h0, 4'd4);
        for (int b = 0; b < 4; b++) begin
            int n = 0;
            while (!out_rsp_valid && n < 50) begin
                tick();
                n++;
            end
            check("burst_beat_valid", 32'(out_rsp_valid), 32'd1);
            if (b == 1) repeat (3) tick();
            in_rsp_ready = 1'b1;
            tick();
            in_rsp_ready = 1'b0;
        end
        in_rsp_ready = 1'b1;
        wait_idle();

        // Range errors: burst crossing ADDR_MAX, and a start beyond it.
        exp_rsp(32'h0, 1'b1, 1'b1);
        send(1'b0, 32'hFFFE, 32'h0, 4'd3);
        wait_idle();
        exp_rsp(32'h0, 1'b1, 1'b1);
        send(1'b0, 32'h10000, 32'h0, 4'd1);
        wait_idle();

        // Burst ending exactly at ADDR_MAX is legal.
        for (int i = 0; i < 3; i++) begin
            exp_strb(1'b0, 32'hFFFD + 32'(i), 32'h0);
            exp_rsp(32'hC0DEFFFD + 32'(i), (i == 2), 1'b0);
        end
        send(1'b0, 32'hFFFD, 32'h0, 4'd3);
        wait_idle();

        // len=0 is one beat; len above MAX_BURST clamps to eight beats.
        exp_strb(1'b0, 32'hFFFF, 32'h0);
        exp_rsp(32'hC0DEFFFF, 1'b1, 1'b0);
        send(1'b0, 32'hFFFF, 32'h0, 4'd0);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            exp_strb(1'b0, 32'h200 + 32'(i), 32'h0);
            exp_rsp(32'hC0DE0200 + 32'(i), (i == 7), 1'b0);
        end
        send(1'b0, 32'h200, 32'h0, 4'd12);
        wait_idle();

        // Reset during the second access of a four-beat load drops the request.
        exp_strb(1'b0, 32'h300, 32'h0);
        exp_strb(1'b0, 32'h301, 32'h0);
        exp_rsp(32'hC0DE0300, 1'b0, 1'b0);
        send(1'b0, 32'h300, 32'h0, 4'd4);
        begin
            int n = 0;
            while (!(out_ctrl_read && out_addr == 32'h301) && n < 50) begin
                tick();
                n++;
            end
            check("mid_access_reached", out_addr, 32'h301);
        end
        in_rst_n = 1'b0;
        tick();
        check("midrst_ctrl_read", 32'(out_ctrl_read), 32'd0);
        check("midrst_ctrl_write", 32'(out_ctrl_write), 32'd0);
        check("midrst_rsp_valid", 32'(out_rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(out_req_ready), 32'd1);
        tick();
        in_rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_rsp_left", 32'(rsp_q.size()), 32'd0);
        check("post_rst_strb_left", 32'(strb_q.size()), 32'd0);
        check("post_rst_req_ready", 32'(out_req_ready), 32'd1);

        // The unit still works normally after the mid-flight reset.
        exp_strb(1'b0, 32'h40, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b1, 1'b0);
        send(1'b0, 32'h40, 32'h0, 4'd1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
